// File: rtl/ctrl_hazard_stage.sv
// rtl/ctrl_hazard_stage.sv - ID/EX control register with stall, flush and multi-cycle NOP bubble insertion
// Optional macro CTRL_HAZARD_STATS_EN adds a saturating nop_count output.
module ctrl_hazard_stage #(
  parameter int           W   = 14,
  parameter int           LW  = 2,
  parameter logic [W-1:0] NOP = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  ctrl_in,
  input  logic          valid_in,
  input  logic          stall,
  input  logic          flush,
  input  logic          bubble_req,
  input  logic [LW-1:0] bubble_len,
`ifdef CTRL_HAZARD_STATS_EN
  output logic [15:0]   nop_count,
`endif
  output logic [W-1:0]  ctrl_out,
  output logic          valid_out,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, BUBBLE = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  ctrl_q, ctrl_d;
  logic          valid_q, valid_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl_d  = ctrl_q;
    valid_d = valid_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      ctrl_d  = NOP;
      valid_d = 1'b0;
    end else if (stall) begin
      state_d = state_q;
    end else if (state_q == BUBBLE) begin
      ctrl_d  = NOP;
      valid_d = 1'b0;
      cnt_d   = cnt_q - LW'(1);
      state_d = (cnt_q == LW'(1)) ? IDLE : BUBBLE;
    end else if (bubble_req) begin
      // A length of 0 is treated as 1, so the counter starts at L-1.
      ctrl_d  = NOP;
      valid_d = 1'b0;
      cnt_d   = (bubble_len == '0) ? '0 : bubble_len - LW'(1);
      state_d = (cnt_d != '0) ? BUBBLE : IDLE;
    end else begin
      ctrl_d  = ctrl_in;
      valid_d = valid_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ctrl_q  <= NOP;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
      valid_q <= valid_d;
    end
  end

  assign ctrl_out  = ctrl_q;
  assign valid_out = valid_q;
  assign busy      = (state_q == BUBBLE);

`ifdef CTRL_HAZARD_STATS_EN
  logic [15:0] nop_count_q, nop_count_d;
  logic        nop_load;

  always_comb begin
    nop_load    = flush | (!stall & ((state_q == BUBBLE) | bubble_req));
    nop_count_d = nop_count_q;
    if (nop_load && nop_count_q != 16'hFFFF)
      nop_count_d = nop_count_q + 16'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) nop_count_q <= '0;
    else       nop_count_q <= nop_count_d;
  end

  assign nop_count = nop_count_q;
`endif

endmodule

// File: tb/tb_ctrl_hazard_stage.sv
// tb/tb_ctrl_hazard_stage.sv - directed and random checks of ctrl_hazard_stage against a remaining-NOP model
module tb_ctrl_hazard_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [13:0] ctrl_in = '0;
  logic        valid_in = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        bubble_req = 1'b0;
  logic [1:0]  bubble_len = '0;
  logic [13:0] ctrl_out;
  logic        valid_out;
  logic        busy;
`ifdef CTRL_HAZARD_STATS_EN
  logic [15:0] nop_count;
`endif

  int total = 0;
  int bad = 0;

  // Reference state: output register and number of NOP edges still owed.
  logic [13:0] m_ctrl;
  logic        m_valid;
  int          m_rem;
  int          m_nops;

  ctrl_hazard_stage #(.W(14), .LW(2), .NOP(14'h0)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .valid_in(valid_in),
    .stall(stall), .flush(flush), .bubble_req(bubble_req), .bubble_len(bubble_len),
`ifdef CTRL_HAZARD_STATS_EN
    .nop_count(nop_count),
`endif
    .ctrl_out(ctrl_out), .valid_out(valid_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
    check("valid_out", 32'(valid_out), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_rem > 0));
`ifdef CTRL_HAZARD_STATS_EN
    check("nop_count", 32'(nop_count), 32'(m_nops));
`endif
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_valid = 1'b0; m_rem = 0; m_nops = 0;
  endtask

  task automatic model_edge();
    if (flush) begin
      m_ctrl = '0; m_valid = 1'b0; m_rem = 0;
      if (m_nops < 65535) m_nops++;
    end else if (stall) begin
      m_rem = m_rem;
    end else if (m_rem > 0) begin
      m_ctrl = '0; m_valid = 1'b0; m_rem--;
      if (m_nops < 65535) m_nops++;
    end else if (bubble_req) begin
      m_ctrl = '0; m_valid = 1'b0;
      m_rem = ((bubble_len == 0) ? 1 : int'(bubble_len)) - 1;
      if (m_nops < 65535) m_nops++;
    end else begin
      m_ctrl = ctrl_in; m_valid = valid_in;
    end
  endtask

  task automatic step(input bit f, input bit s, input bit r, input logic [1:0] len,
                      input logic [13:0] ci, input bit vi);
    flush = f; stall = s; bubble_req = r; bubble_len = len; ctrl_in = ci; valid_in = vi;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 reset = 1'b1;
    #1 model_reset();
    check_all();
    #1 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    #1 check_all();
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Normal flow
    step(0, 0, 0, 0, 14'h2A5F, 1);
    check("normal_ctrl", 32'(ctrl_out), 32'h2A5F);
    check("normal_valid", 32'(valid_out), 32'h1);

    // Three-cycle bubble, requests ignored while busy
    step(0, 0, 1, 3, 14'h1111, 1);
    check("bub3_busy1", 32'(busy), 32'h1);
    step(0, 0, 1, 3, 14'h2222, 1);
    step(0, 0, 1, 1, 14'h3333, 1);
    check("bub3_end_busy", 32'(busy), 32'h0);
    step(0, 0, 0, 0, 14'h0ABC, 1);
    check("bub3_load", 32'(ctrl_out), 32'h0ABC);

    // Stalled bubble of length 2
    model_reset();
    reset = 1'b1; #1 reset = 1'b0;
    check_all();
    step(0, 0, 1, 2, 14'h0555, 1);
    step(0, 1, 0, 0, 14'h0666, 1);
    step(0, 1, 0, 0, 14'h0777, 1);
    check("stall_busy", 32'(busy), 32'h1);
    step(0, 0, 0, 0, 14'h0888, 1);
    step(0, 0, 0, 0, 14'h0999, 0);
`ifdef CTRL_HAZARD_STATS_EN
    check("stall_nops", 32'(nop_count), 32'd2);
`endif

    // Flush on the second edge of a length-3 bubble
    step(0, 0, 1, 3, 14'h1234, 1);
    step(1, 0, 0, 0, 14'h1235, 1);
    check("flush_busy", 32'(busy), 32'h0);
    step(0, 0, 0, 0, 14'h1236, 1);
    check("flush_load", 32'(ctrl_out), 32'h1236);

    // Asynchronous reset mid-bubble
    step(0, 0, 1, 3, 14'h0F0F, 1);
    async_reset();
    step(0, 0, 0, 0, 14'h3F00, 1);

    // bubble_len 0 gives exactly one NOP, never busy
    step(0, 0, 1, 0, 14'h0101, 1);
    check("len0_busy", 32'(busy), 32'h0);
    step(0, 0, 0, 0, 14'h0202, 1);

    // Flush beats stall
    step(0, 0, 1, 3, 14'h0303, 1);
    step(1, 1, 0, 0, 14'h0404, 1);
    check("flush_stall_busy", 32'(busy), 32'h0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 10) == 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
           2'($urandom), 14'($urandom), 1'($urandom));
      if (($urandom % 60) == 0) async_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
